multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM for the MIPS-subset core; replaces the single-cycle opcode decoder as the datapath sequencer.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives PC, IR, register-file, ALU and memory strobes.
- Handles req/ack handshakes to the instruction and data memories, with a timeout.

---
 rtl/multicycle_sequencer_pkg.sv | 82 ++++++++
 rtl/multicycle_sequencer_mem_wait_timer.sv | 39 +++
 rtl/multicycle_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, ALU codes, state
// and output-field encodings, plus the per-cycle strobe bundle.
package multicycle_sequencer_pkg;

    localparam logic [5:0] GENERIC_R = 6'd0;
    localparam logic [5:0] JUMP      = 6'd2;
    localparam logic [5:0] JAL       = 6'd3;
    localparam logic [5:0] BEQ       = 6'd4;
    localparam logic [5:0] BNE       = 6'd5;
    localparam logic [5:0] ADDI      = 6'd8;
    localparam logic [5:0] ADDIU     = 6'd9;
    localparam logic [5:0] SLTI      = 6'd10;
    localparam logic [5:0] SLTIU     = 6'd11;
    localparam logic [5:0] ANDI      = 6'd12;
    localparam logic [5:0] ORI       = 6'd13;
    localparam logic [5:0] LUI       = 6'd15;
    localparam logic [5:0] LW        = 6'd35;
    localparam logic [5:0] SW        = 6'd43;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam int unsigned TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        DST_RT  = 2'b00,
        DST_RD  = 2'b01,
        DST_R31 = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LUI  = 2'b10,
        WB_LINK = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        CLS_ADD   = 2'b00,
        CLS_SUB   = 2'b01,
        CLS_FUNCT = 2'b10,
        CLS_IOP   = 2'b11
    } alu_class_e;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_inc;
        logic       pc_jump;
        logic       pc_branch;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_write;
        reg_dst_e   reg_dst;
        logic       alu_src;
        alu_class_e alu_class;
        logic [3:0] i_op;
        wb_sel_e    wb_sel;
        logic       instr_retired;
    } strobes_t;

    function automatic logic is_known_op(input logic [5:0] op);
        case (op)
            GENERIC_R, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU,
            ANDI, ORI, LUI, LW, SW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Memory handshake wait counter shared by FETCH and MEM; flags a timeout when
// a request has sat unacknowledged for MEM_TIMEOUT cycles.
module mem_wait_timer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic ack_i,
    output logic timeout_o
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(MEM_TIMEOUT);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    // An ack in the limit cycle suppresses the timeout.
    assign timeout_o = req_i && !ack_i && (cnt_q == LIMIT);

    // Every exit from a waiting state is via ack or timeout, so clearing on
    // those (or on req low) also clears on any state change.
    always_comb begin
        cnt_d = cnt_q + TIMER_W'(1);
        if (!req_i || ack_i || timeout_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset core.
// Define ILLEGAL_OP_TRAP_EN to halt on unknown opcodes instead of retiring them as NOPs.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_inc,
    output logic       pc_jump,
    output logic       pc_branch,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic       alu_src,
    output logic [1:0] alu_class,
    output logic [3:0] i_op,
    output logic [1:0] wb_sel,
    output logic       instr_retired,
    output logic       bus_err,
    output logic       illegal_op,
    output logic       halted,
    output logic [2:0] state
);

    state_e     state_q, state_d;
    logic [5:0] opcode_q;
    logic       bus_err_q;
    logic       set_bus_err;
    logic       wait_req, wait_ack, timeout;
    strobes_t   str, str_o;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_q;
    logic       set_illegal;
`endif

    assign wait_req = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign wait_ack = (state_q == ST_FETCH) ? imem_ack : dmem_ack;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .req_i    (wait_req),
        .ack_i    (wait_ack),
        .timeout_o(timeout)
    );

    always_comb begin
        state_d     = state_q;
        str         = '0;
        set_bus_err = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        set_illegal = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
                str.imem_req = 1'b1;
                if (imem_ack) begin
                    str.ir_write = 1'b1;
                    str.pc_inc   = 1'b1;
                    state_d      = ST_DECODE;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_d     = ST_HALT;
                end
            end
            ST_DECODE: begin
                // The opcode is not registered yet, so DECODE looks at the live IR field.
                case (opcode)
                    JUMP: begin
                        str.pc_jump       = 1'b1;
                        str.instr_retired = 1'b1;
                        state_d           = ST_FETCH;
                    end
                    JAL: begin
                        str.pc_jump = 1'b1;
                        state_d     = ST_WB;
                    end
                    default: begin
                        if (is_known_op(opcode)) begin
                            state_d = ST_EXEC;
                        end else begin
`ifdef ILLEGAL_OP_TRAP_EN
                            set_illegal = 1'b1;
                            state_d     = ST_HALT;
`else
                            str.instr_retired = 1'b1;
                            state_d           = ST_FETCH;
`endif
                        end
                    end
                endcase
            end
            ST_EXEC: begin
                state_d = ST_WB;
                case (opcode_q)
                    GENERIC_R: str.alu_class = CLS_FUNCT;
                    LW, SW: begin
                        str.alu_class = CLS_ADD;
                        str.alu_src   = 1'b1;
                        state_d       = ST_MEM;
                    end
                    BEQ, BNE: begin
                        str.alu_class     = CLS_SUB;
                        str.pc_branch     = (opcode_q == BEQ) ? alu_zero : !alu_zero;
                        str.instr_retired = 1'b1;
                        state_d           = ST_FETCH;
                    end
                    ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI: begin
                        str.alu_class = CLS_IOP;
                        str.alu_src   = 1'b1;
                        case (opcode_q)
                            SLTI, SLTIU: str.i_op = ALU_SLT;
                            ANDI:        str.i_op = ALU_AND;
                            ORI:         str.i_op = ALU_OR;
                            default:     str.i_op = ALU_ADD;
                        endcase
                    end
                    LUI: begin
                        str.alu_class = CLS_ADD;
                        str.alu_src   = 1'b1;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                str.dmem_req = 1'b1;
                str.dmem_we  = (opcode_q == SW);
                if (dmem_ack) begin
                    if (opcode_q == SW) begin
                        str.instr_retired = 1'b1;
                        state_d           = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_d     = ST_HALT;
                end
            end
            ST_WB: begin
                str.reg_write     = 1'b1;
                str.instr_retired = 1'b1;
                state_d           = ST_FETCH;
                case (opcode_q)
                    GENERIC_R: str.reg_dst = DST_RD;
                    LW:        str.wb_sel  = WB_MEM;
                    LUI:       str.wb_sel  = WB_LUI;
                    JAL: begin
                        str.reg_dst = DST_R31;
                        str.wb_sel  = WB_LINK;
                    end
                    default: begin
                        str.reg_dst = DST_RT;
                        str.wb_sel  = WB_ALU;
                    end
                endcase
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_FETCH;
            opcode_q  <= '0;
            bus_err_q <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                opcode_q <= opcode;
            end
            if (set_bus_err) begin
                bus_err_q <= 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
`endif
        end
    end

    // Reset drives FETCH, which would otherwise raise imem_req while rst is low.
    assign str_o = rst ? str : '0;

    assign imem_req      = str_o.imem_req;
    assign ir_write      = str_o.ir_write;
    assign pc_inc        = str_o.pc_inc;
    assign pc_jump       = str_o.pc_jump;
    assign pc_branch     = str_o.pc_branch;
    assign dmem_req      = str_o.dmem_req;
    assign dmem_we       = str_o.dmem_we;
    assign reg_write     = str_o.reg_write;
    assign reg_dst       = str_o.reg_dst;
    assign alu_src       = str_o.alu_src;
    assign alu_class     = str_o.alu_class;
    assign i_op          = str_o.i_op;
    assign wb_sel        = str_o.wb_sel;
    assign instr_retired = str_o.instr_retired;
    assign bus_err       = bus_err_q;
`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op    = illegal_q;
`else
    assign illegal_op    = 1'b0;
`endif
    assign halted        = (state_q == ST_HALT);
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle expected outputs are queued
// as each step is driven and compared at the following falling edge.
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    localparam int unsigned TO   = 4;
    localparam logic [5:0]  JUNK = 6'h3F;
    localparam logic [2:0]  S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic       alu_zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic       imem_req, ir_write, pc_inc, pc_jump, pc_branch, dmem_req, dmem_we, reg_write;
    logic [1:0] reg_dst, alu_class, wb_sel;
    logic       alu_src, instr_retired, bus_err, illegal_op, halted;
    logic [3:0] i_op;
    logic [2:0] state;

    multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
        .ir_write(ir_write), .pc_inc(pc_inc), .pc_jump(pc_jump), .pc_branch(pc_branch),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write), .reg_dst(reg_dst),
        .alu_src(alu_src), .alu_class(alu_class), .i_op(i_op), .wb_sel(wb_sel),
        .instr_retired(instr_retired), .bus_err(bus_err), .illegal_op(illegal_op),
        .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, ir_write, pc_inc, pc_jump, pc_branch, dmem_req, dmem_we, reg_write;
        logic [1:0] reg_dst;
        logic       alu_src;
        logic [1:0] alu_class;
        logic [3:0] i_op;
        logic [1:0] wb_sel;
        logic       retired, bus_err, illegal, halted;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  exp;
    } sb_item_t;

    sb_item_t sb[$];
    int       checks = 0;
    int       errors = 0;
    logic     eb = 1'b0;
    logic     ei = 1'b0;

    function automatic obs_t base(input logic [2:0] st);
        obs_t o = '0;
        o.st      = st;
        o.bus_err = eb;
        o.illegal = ei;
        o.halted  = (st == S_H);
        return o;
    endfunction

    function automatic obs_t fwait();
        obs_t o = base(S_F);
        o.imem_req = 1'b1;
        return o;
    endfunction

    function automatic obs_t fack();
        obs_t o = fwait();
        o.ir_write = 1'b1;
        o.pc_inc   = 1'b1;
        return o;
    endfunction

    function automatic obs_t dc(input logic jmp, input logic ret);
        obs_t o = base(S_D);
        o.pc_jump = jmp;
        o.retired = ret;
        return o;
    endfunction

    function automatic obs_t ex(input logic [1:0] cls, input logic src, input logic [3:0] iop,
                                input logic br, input logic ret);
        obs_t o = base(S_E);
        o.alu_class = cls;
        o.alu_src   = src;
        o.i_op      = iop;
        o.pc_branch = br;
        o.retired   = ret;
        return o;
    endfunction

    function automatic obs_t mem(input logic we, input logic ret);
        obs_t o = base(S_M);
        o.dmem_req = 1'b1;
        o.dmem_we  = we;
        o.retired  = ret;
        return o;
    endfunction

    function automatic obs_t wb(input logic [1:0] dst, input logic [1:0] sel);
        obs_t o = base(S_W);
        o.reg_write = 1'b1;
        o.retired   = 1'b1;
        o.reg_dst   = dst;
        o.wb_sel    = sel;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = state;           o.imem_req = imem_req;   o.ir_write = ir_write;
        o.pc_inc = pc_inc;      o.pc_jump = pc_jump;     o.pc_branch = pc_branch;
        o.dmem_req = dmem_req;  o.dmem_we = dmem_we;     o.reg_write = reg_write;
        o.reg_dst = reg_dst;    o.alu_src = alu_src;     o.alu_class = alu_class;
        o.i_op = i_op;          o.wb_sel = wb_sel;       o.retired = instr_retired;
        o.bus_err = bus_err;    o.illegal = illegal_op;  o.halted = halted;
        return o;
    endfunction

    task automatic check_next(input obs_t act);
        sb_item_t it;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow: observed=%h expected=<queued entry>", act);
        end else begin
            it = sb.pop_front();
            assert (act === it.exp) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", it.tag, act, it.exp);
            end
        end
    endtask

    // Drive one cycle of inputs, queue its expected outputs, compare at the falling edge.
    task automatic cyc(input logic ia, input logic da, input logic az, input logic [5:0] op,
                       input string tag, input obs_t exp);
        sb_item_t it;
        imem_ack = ia;
        dmem_ack = da;
        alu_zero = az;
        opcode   = op;
        it.tag   = tag;
        it.exp   = exp;
        sb.push_back(it);
        @(negedge clk);
        check_next(sample());
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int unsigned waits, input string tag);
        for (int unsigned i = 0; i < waits; i++) begin
            cyc(1'b0, 1'b0, 1'b0, JUNK, {tag, "_F_wait"}, fwait());
        end
        cyc(1'b1, 1'b0, 1'b0, JUNK, {tag, "_F_ack"}, fack());
    endtask

    task automatic alu_instr(input logic [5:0] op, input int unsigned waits, input string tag,
                             input obs_t e_exp, input obs_t w_exp);
        fetch(waits, tag);
        cyc(1'b0, 1'b0, 1'b0, op, {tag, "_D"}, dc(1'b0, 1'b0));
        cyc(1'b0, 1'b0, 1'b0, JUNK, {tag, "_E"}, e_exp);
        cyc(1'b0, 1'b0, 1'b0, JUNK, {tag, "_WB"}, w_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b1, 1'b1, ADDI, "reset_outputs", '0);
        rst = 1'b1;

        alu_instr(ADDI, 2, "addi", ex(2'b11, 1'b1, ALU_ADD, 1'b0, 1'b0), wb(2'b00, 2'b00));

        fetch(0, "lw");
        cyc(1'b0, 1'b0, 1'b0, LW, "lw_D", dc(1'b0, 1'b0));
        cyc(1'b0, 1'b0, 1'b0, JUNK, "lw_E", ex(2'b00, 1'b1, 4'd0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, JUNK, "lw_M_wait", mem(1'b0, 1'b0));
        cyc(1'b0, 1'b1, 1'b0, JUNK, "lw_M_ack", mem(1'b0, 1'b0));
        cyc(1'b0, 1'b0, 1'b0, JUNK, "lw_WB", wb(2'b00, 2'b01));

        fetch(0, "sw");
        cyc(1'b0, 1'b0, 1'b0, SW, "sw_D", dc(1'b0, 1'b0));
        cyc(1'b0, 1'b0, 1'b0, JUNK, "sw_E", ex(2'b00, 1'b1, 4'd0, 1'b0, 1'b0));
        cyc(1'b0, 1'b1, 1'b0, JUNK, "sw_M_ack", mem(1'b1, 1'b1));

        fetch(0, "beq");
        cyc(1'b0, 1'b0, 1'b0, BEQ, "beq_D", dc(1'b0, 1'b0));
        cyc(1'b0, 1'b0, 1'b1, JUNK, "beq_E_z1", ex(2'b01, 1'b0, 4'd0, 1'b1, 1'b1));
        fetch(0, "bne");
        cyc(1'b0, 1'b0, 1'b0, BNE, "bne_D", dc(1'b0, 1'b0));
        cyc(1'b0, 1'b0, 1'b1, JUNK, "bne_E_z1", ex(2'b01, 1'b0, 4'd0, 1'b0, 1'b1));
        fetch(0, "bne2");
        cyc(1'b0, 1'b0, 1'b0, BNE, "bne2_D", dc(1'b0, 1'b0));
        cyc(1'b0, 1'b0, 1'b0, JUNK, "bne2_E_z0", ex(2'b01, 1'b0, 4'd0, 1'b1, 1'b1));

        fetch(0, "jal");
        cyc(1'b0, 1'b0, 1'b0, JAL, "jal_D", dc(1'b1, 1'b0));
        cyc(1'b0, 1'b0, 1'b0, JUNK, "jal_WB", wb(2'b10, 2'b11));
        fetch(0, "j");
        cyc(1'b0, 1'b0, 1'b0, JUMP, "j_D", dc(1'b1, 1'b1));

        alu_instr(GENERIC_R, 0, "rtype", ex(2'b10, 1'b0, 4'd0, 1'b0, 1'b0), wb(2'b01, 2'b00));
        alu_instr(LUI, 0, "lui", ex(2'b00, 1'b1, 4'd0, 1'b0, 1'b0), wb(2'b00, 2'b10));
        alu_instr(SLTIU, 0, "sltiu", ex(2'b11, 1'b1, ALU_SLT, 1'b0, 1'b0), wb(2'b00, 2'b00));
        alu_instr(ANDI, 0, "andi", ex(2'b11, 1'b1, ALU_AND, 1'b0, 1'b0), wb(2'b00, 2'b00));
        alu_instr(ORI, 0, "ori", ex(2'b11, 1'b1, ALU_OR, 1'b0, 1'b0), wb(2'b00, 2'b00));
        alu_instr(ADDIU, TO, "fetch_limit_ack", ex(2'b11, 1'b1, ALU_ADD, 1'b0, 1'b0), wb(2'b00, 2'b00));

        fetch(0, "lw_lim");
        cyc(1'b0, 1'b0, 1'b0, LW, "lw_lim_D", dc(1'b0, 1'b0));
        cyc(1'b0, 1'b0, 1'b0, JUNK, "lw_lim_E", ex(2'b00, 1'b1, 4'd0, 1'b0, 1'b0));
        for (int unsigned i = 0; i < TO; i++) cyc(1'b0, 1'b0, 1'b0, JUNK, "lw_lim_M_wait", mem(1'b0, 1'b0));
        cyc(1'b0, 1'b1, 1'b0, JUNK, "lw_lim_M_ack", mem(1'b0, 1'b0));
        cyc(1'b0, 1'b0, 1'b0, JUNK, "lw_lim_WB", wb(2'b00, 2'b01));

        fetch(0, "sw_to");
        cyc(1'b0, 1'b0, 1'b0, SW, "sw_to_D", dc(1'b0, 1'b0));
        cyc(1'b0, 1'b0, 1'b0, JUNK, "sw_to_E", ex(2'b00, 1'b1, 4'd0, 1'b0, 1'b0));
        for (int unsigned i = 0; i <= TO; i++) cyc(1'b0, 1'b0, 1'b0, JUNK, "sw_to_M_wait", mem(1'b1, 1'b0));
        eb = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, JUNK, "dmem_timeout_halt", base(S_H));
        rst = 1'b0;
        eb  = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, JUNK, "reset_from_dmem_halt", '0);
        rst = 1'b1;

        for (int unsigned i = 0; i <= TO; i++) cyc(1'b0, 1'b0, 1'b0, JUNK, "imem_to_F_wait", fwait());
        eb = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, ADDI, "imem_timeout_halt", base(S_H));
        rst = 1'b0;
        eb  = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, JUNK, "reset_mid_halt", '0);
        rst = 1'b1;

        fetch(0, "op63");
`ifdef ILLEGAL_OP_TRAP_EN
        cyc(1'b0, 1'b0, 1'b0, 6'd63, "op63_D_trap", dc(1'b0, 1'b0));
        ei = 1'b1;
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, JUNK, "op63_halt", base(S_H));
`else
        cyc(1'b0, 1'b0, 1'b0, 6'd63, "op63_D_nop", dc(1'b0, 1'b1));
        alu_instr(ADDI, 1, "after_nop", ex(2'b11, 1'b1, ALU_ADD, 1'b0, 1'b0), wb(2'b00, 2'b00));
`endif

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed=%0d leftover expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
